// File: rtl/mips_boot_pkg.sv
// Shared types and sizes for the MIPS boot loader: FSM states and frame geometry.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    RUN,
    ERROR
  } boot_state_t;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LEN_W          = 16;

endpackage

// File: rtl/boot_word_packer.sv
// Shifts accepted bytes into a big-endian 32-bit word and flags the byte that completes it.
module boot_word_packer
  import mips_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_done_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned IDX_W   = $clog2(BYTES_PER_WORD);
  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [IDX_W-1:0]   idx;
  logic [SHIFT_W-1:0] shift;

  // The completing byte is combined combinationally so the caller can register the full word.
  assign word_done_c = byte_valid && (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word_c      = {shift, byte_in};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx   <= '0;
      shift <= '0;
    end else if (byte_valid) begin
      idx   <= idx + IDX_W'(1);
      shift <= word_c[SHIFT_W-1:0];
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory and
// holds the CPU in reset until the image is verified.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                reload,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic                cpu_reset,
  output logic                load_done,
  output logic                load_error,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  boot_state_t       state;
  logic [BYTE_W-1:0] len_hi;
  logic [BYTE_W-1:0] xor_acc;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_c;
  logic              accept_c;
  logic              reload_c;
  logic              pack_valid_c;
  logic              len_bad_c;
  logic              last_word_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_c;

  assign accept_c     = rx_valid && rx_ready;
  assign reload_c     = reload && ((state == RUN) || (state == ERROR));
  assign pack_valid_c = accept_c && (state == DATA);
  assign len_c        = {len_hi, rx_data};
  assign len_bad_c    = (len_c == '0) || (32'(len_c) > IMEM_DEPTH);
  assign last_word_c  = (LEN_W'(words_loaded) + LEN_W'(1)) == len;

  boot_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (reload_c),
    .byte_valid  (pack_valid_c),
    .byte_in     (rx_data),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  // rx_ready is registered from the next state so it always mirrors the loading states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN_HI;
      len_hi       <= '0;
      len          <= '0;
      xor_acc      <= '0;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we  <= 1'b0;
      rx_ready <= (state != RUN) && (state != ERROR);
      if (reload_c) begin
        state        <= LEN_HI;
        xor_acc      <= '0;
        rx_ready     <= 1'b1;
        cpu_reset    <= 1'b1;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= '0;
      end else if (accept_c) begin
        case (state)
          LEN_HI: begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            len <= len_c;
            if (len_bad_c) begin
              state      <= ERROR;
              rx_ready   <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            xor_acc <= xor_acc ^ rx_data;
            if (word_done_c) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= word_c;
              words_loaded <= words_loaded + CNT_W'(1);
              if (last_word_c) state <= CHECK;
            end
          end
          CHECK: begin
            rx_ready <= 1'b0;
            if (rx_data == xor_acc) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: randomized frames checked against a frame-level model.
module tb_mips_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int failures = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  mips_boot_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Capture every memory write as seen by the instruction memory.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present bytes at negedge; a byte counts as sent when rx_valid and rx_ready are both high.
  task automatic send_bytes(input logic [7:0] q[$], input bit rand_valid, output int sent);
    int cyc;
    cyc  = 0;
    sent = 0;
    while (sent < q.size() && cyc < 20 * q.size() + 20) begin
      @(negedge clk);
      if (rand_valid && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = q[sent];
      end
      if (rx_valid && rx_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata} !== {1'b0, 1'b0, 8'h00, 32'h0}) begin
      failures++;
      $display("FAIL reset_bus: got ready=%b we=%b addr=%h wdata=%h, want 0 0 00 00000000",
               rx_ready, imem_we, imem_addr, imem_wdata);
    end
    checks++;
    if ({cpu_reset, load_done, load_error, words_loaded} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
      failures++;
      $display("FAIL reset_status: got cpu_reset=%b done=%b err=%b words=%0d, want 1 0 0 0",
               cpu_reset, load_done, load_error, words_loaded);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b want 1", rx_ready);
    end
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checks++;
    if ({cpu_reset, load_done, load_error, words_loaded, rx_ready} !==
        {1'b1, 1'b0, 1'b0, 9'd0, 1'b1}) begin
      failures++;
      $display("FAIL reload_state: got cpu_reset=%b done=%b err=%b words=%0d ready=%b, want 1 0 0 0 1",
               cpu_reset, load_done, load_error, words_loaded, rx_ready);
    end
  endtask

  // Frame-level model: valid length -> words at addresses 0..N-1; RUN iff checksum is the XOR of data bytes.
  task automatic run_frame(input string name, input logic [15:0] n, input logic [31:0] w[$],
                           input bit bad_cs, input bit rand_valid);
    logic [7:0] body[$];
    logic [7:0] cs_q[$];
    logic [7:0] cs;
    logic [7:0] by;
    int sent;
    bit ok_len;
    cs = 8'h00;
    ok_len = (n != 16'd0) && (n <= 16'd256);
    wr_addr.delete();
    wr_data.delete();
    body.push_back(n[15:8]);
    body.push_back(n[7:0]);
    if (ok_len) begin
      foreach (w[i]) begin
        for (int b = 3; b >= 0; b--) begin
          by = 8'(w[i] >> (8 * b));
          body.push_back(by);
          cs = cs ^ by;
        end
      end
    end
    send_bytes(body, rand_valid, sent);
    checks++;
    if (sent != body.size()) begin
      failures++;
      $display("FAIL %s timeout: sent %0d of %0d bytes", name, sent, body.size());
    end
    if (!ok_len) begin
      checks++;
      if ({load_error, cpu_reset, rx_ready, load_done} !== 4'b1100) begin
        failures++;
        $display("FAIL %s bad_len_state: got err=%b cpu_reset=%b ready=%b done=%b, want 1 1 0 0",
                 name, load_error, cpu_reset, rx_ready, load_done);
      end
      checks++;
      if (wr_addr.size() != 0) begin
        failures++;
        $display("FAIL %s bad_len_writes: got %0d writes want 0", name, wr_addr.size());
      end
      return;
    end
    checks++;
    if ({cpu_reset, load_done} !== 2'b10) begin
      failures++;
      $display("FAIL %s pre_cs: got cpu_reset=%b done=%b want 1 0", name, cpu_reset, load_done);
    end
    cs_q.push_back(bad_cs ? (cs ^ 8'h01) : cs);
    send_bytes(cs_q, rand_valid, sent);
    checks++;
    if (sent != 1) begin
      failures++;
      $display("FAIL %s cs_timeout: checksum byte not accepted", name);
    end
    checks++;
    if ({cpu_reset, load_done, load_error} !== {bad_cs, !bad_cs, bad_cs}) begin
      failures++;
      $display("FAIL %s result: got cpu_reset=%b done=%b err=%b want %b %b %b",
               name, cpu_reset, load_done, load_error, bad_cs, !bad_cs, bad_cs);
    end
    checks++;
    if (words_loaded !== 9'(n)) begin
      failures++;
      $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, n);
    end
    checks++;
    if (wr_addr.size() != int'(n)) begin
      failures++;
      $display("FAIL %s write_count: got %0d want %0d", name, wr_addr.size(), n);
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        checks++;
        if (wr_addr[i] !== 8'(i) || wr_data[i] !== w[i]) begin
          failures++;
          $display("FAIL %s write[%0d]: got addr=%h data=%h want addr=%h data=%h",
                   name, i, wr_addr[i], wr_data[i], 8'(i), w[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    w = '{32'h20080005, 32'h00000008};
    run_frame("basic", 16'd2, w, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    logic [31:0] w[$];
    logic [7:0] extra[$];
    int sent;
    w = '{32'h20080005, 32'h00000008};
    pulse_reload();
    run_frame("bad_cs", 16'd2, w, 1'b1, 1'b0);
    extra.push_back(8'h5A);
    send_bytes(extra, 1'b0, sent);
    checks++;
    if (sent != 0 || rx_ready !== 1'b0 || load_error !== 1'b1 || words_loaded !== 9'd2) begin
      failures++;
      $display("FAIL error_hold: got sent=%0d ready=%b err=%b words=%0d want 0 0 1 2",
               sent, rx_ready, load_error, words_loaded);
    end
  endtask

  task automatic test_bad_length();
    logic [31:0] w[$];
    pulse_reload();
    run_frame("len_zero", 16'h0000, w, 1'b0, 1'b0);
    pulse_reload();
    run_frame("len_over", 16'h0101, w, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    logic [31:0] w[$];
    int n;
    w = '{32'h20080005, 32'h00000008};
    pulse_reload();
    run_frame("stall_basic", 16'd2, w, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      w.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) w.push_back(32'($urandom));
      pulse_reload();
      run_frame("stall_rand", 16'(n), w, (k == 2), 1'b1);
    end
  endtask

  task automatic test_max_depth();
    logic [31:0] w[$];
    for (int i = 0; i < 256; i++) w.push_back(32'($urandom));
    pulse_reload();
    run_frame("max_depth", 16'd256, w, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] part[$];
    logic [31:0] w[$];
    int sent;
    pulse_reload();
    part.push_back(8'h00);
    part.push_back(8'h03);
    for (int i = 0; i < 6; i++) part.push_back(8'($urandom));
    send_bytes(part, 1'b0, sent);
    // reload must be ignored while a frame is in progress
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checks++;
    if (sent != 8 || words_loaded !== 9'd1 || rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL reload_ignored: got sent=%0d words=%0d ready=%b cpu_reset=%b want 8 1 1 1",
               sent, words_loaded, rx_ready, cpu_reset);
    end
    do_reset();
    w = '{32'($urandom), 32'($urandom)};
    run_frame("after_reset", 16'd2, w, 1'b0, 1'b0);
  endtask

  task automatic test_reload();
    logic [31:0] w[$];
    w = '{32'hDEADBEEF};
    pulse_reload();
    run_frame("reload_deadbeef", 16'd1, w, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_bad_length();
    test_stall();
    test_max_depth();
    test_reset_mid();
    test_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
